// File: rtl/fifo_tx_drain_ctrl.sv
// fifo_tx_drain_ctrl: read-side scheduler for the 8-entry TX byte FIFO.
// Starts a drain burst when occupancy reaches THRESHOLD, or when a
// non-empty, below-threshold FIFO has waited TIMEOUT cycles. It pops one
// byte at a time and hands it to the UART transmitter through a
// start/busy handshake, continuing until the FIFO is empty.
module fifo_tx_drain_ctrl #(
  parameter int THRESHOLD = 4,     // 1..7
  parameter int TIMEOUT   = 1000   // 1..65535
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [2:0]  i_fifo_wptr,
  input  logic [2:0]  i_fifo_rptr,
  input  logic        i_fifo_empty,
  input  logic [7:0]  i_fifo_data,
  output logic        o_fifo_rd_en,
  input  logic        i_tx_busy,
  output logic        o_tx_start,
  output logic [7:0]  o_tx_data,
  output logic [2:0]  o_occupancy,
  output logic        o_busy,
  output logic [15:0] o_sent_count
);

  localparam logic [2:0]  THR     = 3'(THRESHOLD);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_START,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  state_t      r_state;
  logic        r_rd_en;
  logic [7:0]  r_tx_data;
  logic        r_busy;
  logic [15:0] r_sent_count;
  logic [15:0] r_to_cnt;

  logic [2:0]  w_occ;
  logic        w_at_thr;
  logic        w_to_hit;
  logic        w_more;
  logic        w_trigger;
  logic        w_to_count;
  logic        w_start_ok;

  // Pointer difference wraps mod 8; a full 8-entry FIFO is never reported.
  assign w_occ      = i_fifo_wptr - i_fifo_rptr;
  assign w_at_thr   = (w_occ >= THR);
  assign w_to_hit   = (r_to_cnt == TO_LAST);
  assign w_more     = i_enable && !i_fifo_empty;
  assign w_trigger  = w_more && (w_at_thr || w_to_hit);
  assign w_to_count = w_more && !w_at_thr;

  // The transmitter must see the request in the same cycle START notices it
  // is free, so the pulse is decoded from the state register and tx_busy.
  assign w_start_ok = (r_state == S_START) && !i_tx_busy;

  // Burst sequencer, idle-timeout counter and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_rd_en      <= 1'b0;
      r_tx_data    <= 8'h00;
      r_busy       <= 1'b0;
      r_sent_count <= 16'h0000;
      r_to_cnt     <= 16'h0000;
    end else begin
      r_rd_en  <= 1'b0;
      r_to_cnt <= 16'h0000;
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_state <= S_READ;
            r_rd_en <= 1'b1;
            r_busy  <= 1'b1;
          end else if (w_to_count) begin
            r_to_cnt <= r_to_cnt + 16'd1;
          end
        end
        S_READ: begin
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // FIFO read data is registered, so it is valid one cycle after the pop.
          r_tx_data <= i_fifo_data;
          r_state   <= S_START;
        end
        S_START: begin
          if (w_start_ok) begin
            r_sent_count <= r_sent_count + 16'd1;
            r_state      <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (i_tx_busy) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!i_tx_busy) begin
            // Burst continues regardless of threshold while data remains.
            if (w_more) begin
              r_state <= S_READ;
              r_rd_en <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_fifo_rd_en = r_rd_en;
  assign o_tx_start   = w_start_ok;
  assign o_tx_data    = r_tx_data;
  assign o_occupancy  = w_occ;
  assign o_busy       = r_busy;
  assign o_sent_count = r_sent_count;

  // Structural invariants of the handshake.
  a_start_single: assert property (@(posedge i_clk) disable iff (i_reset)
    o_tx_start |=> !o_tx_start);
  a_rd_in_read: assert property (@(posedge i_clk) disable iff (i_reset)
    o_fifo_rd_en |-> (r_state == S_READ));
  a_busy_state: assert property (@(posedge i_clk) disable iff (i_reset)
    o_busy == (r_state != S_IDLE));

endmodule

// File: tb/tb_fifo_tx_drain_ctrl.sv
// Bench for fifo_tx_drain_ctrl: behavioural FIFO and transmitter around the
// DUT, a byte scoreboard filled on every write, and a negedge monitor.
module tb_fifo_tx_drain_ctrl;
  localparam int THR = 4;
  localparam int TO  = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [2:0]  wptr = 3'd0;
  logic [2:0]  rptr = 3'd0;
  logic [7:0]  fdata = 8'h00;
  logic [7:0]  mem [8];
  logic        empty;
  logic        rd_en;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [2:0]  occ;
  logic        busy;
  logic [15:0] sent;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbq [$];

  // transmitter model controls
  logic tx_force = 1'b0;
  logic go = 1'b0;
  int   dur = 1;
  int   tx_cnt = 0;
  int   fixed_dur = 0;

  // monitor state
  logic       rst_seen = 1'b0;
  logic       pend_valid = 1'b0;
  logic [7:0] pend = 8'h00;
  int         exp_sent = 0;
  int         cyc = 0;
  int         rd_cyc = 0;
  logic       prev_start = 1'b0;
  logic       in_tx = 1'b0;
  logic       busy_seen = 1'b0;
  logic       exp_rd_chk = 1'b0;
  logic       exp_rd = 1'b0;

  assign empty = (wptr == rptr);

  always #5 clk = ~clk;

  fifo_tx_drain_ctrl #(.THRESHOLD(THR), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable),
    .i_fifo_wptr(wptr), .i_fifo_rptr(rptr), .i_fifo_empty(empty),
    .i_fifo_data(fdata), .o_fifo_rd_en(rd_en), .i_tx_busy(tx_busy),
    .o_tx_start(tx_start), .o_tx_data(tx_data), .o_occupancy(occ),
    .o_busy(busy), .o_sent_count(sent)
  );

  // FIFO read port: registered data, pointer advances on each pop
  always @(posedge clk) begin
    if (rd_en) begin
      fdata <= mem[rptr];
      rptr  <= rptr + 3'd1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    mem[wptr] = b;
    wptr = wptr + 3'd1;
    sbq.push_back(b);
  endtask

  task automatic push(input logic [7:0] b);
    @(posedge clk); #1;
    wr(b);
  endtask

  task automatic wait_rd(input string nm);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!rd_en && n < 200);
    chk(nm, rd_en, 1);
  endtask

  task automatic wait_drained(input string nm);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
      while (!(empty && !busy && !tx_busy) && n < 3000);
    chk(nm, (empty && !busy && !tx_busy), 1);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // transmitter: busy for dur cycles after each sampled start, or forced
  initial begin
    forever begin
      @(posedge clk); #1;
      if (tx_cnt > 0) tx_cnt--;
      if (go) begin tx_cnt = dur; go = 1'b0; end
      tx_busy = tx_force || (tx_cnt > 0);
    end
  end

  // monitor / scoreboard
  initial begin
    logic [2:0] eo;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_seen) begin
        chk("rst_rd_en", rd_en, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sent", sent, 0);
      end else begin
        eo = wptr - rptr;
        chk("occupancy", occ, eo);
        chk("sent_count", sent, exp_sent[15:0]);
        if (exp_rd_chk) begin
          chk("next_read", rd_en, exp_rd);
          if (!exp_rd) chk("idle_busy", busy, 0);
          exp_rd_chk = 1'b0;
        end
        if (rd_en) begin
          chk("pop_nonempty", empty, 0);
          chk("pop_has_data", (sbq.size() > 0), 1);
          if (sbq.size() > 0) pend = sbq.pop_front();
          pend_valid = 1'b1;
          rd_cyc = cyc;
        end
        if (pend_valid && cyc == rd_cyc + 2) chk("start_latency", tx_start, !tx_busy);
        if (tx_start) begin
          chk("start_gap", prev_start, 0);
          chk("start_has_byte", pend_valid, 1);
          if (pend_valid) chk("tx_data", tx_data, pend);
          pend_valid = 1'b0;
          exp_sent = (exp_sent + 1) & 16'hFFFF;
          in_tx = 1'b1;
          busy_seen = 1'b0;
          dur = (fixed_dur != 0) ? fixed_dur : int'($urandom_range(1, 5));
          go = 1'b1;
        end else if (in_tx) begin
          if (tx_busy) busy_seen = 1'b1;
          else if (busy_seen) begin
            in_tx = 1'b0;
            exp_rd_chk = 1'b1;
            exp_rd = enable && !empty;
          end
        end
      end
      prev_start = tx_start;
      if (reset) begin
        pend_valid = 1'b0;
        exp_sent = 0;
        in_tx = 1'b0;
        exp_rd_chk = 1'b0;
      end
      rst_seen = reset;
    end
  end

  // stimulus
  initial begin
    int n;
    int cnt;
    int bad;
    logic [7:0] d;
    logic [2:0] room;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // threshold burst
    enable = 1'b1;
    fixed_dur = 10;
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    n = 0;
    forever begin @(negedge clk); if (rd_en) break; n++; if (n > 50) break; end
    chk("thr_latency", n, 1);
    wait_drained("thr_drain");
    chk("thr_sent", sent, 4);
    chk("thr_idle", busy, 0);
    chk("thr_sb_empty", sbq.size(), 0);

    // timeout burst
    fixed_dur = 0;
    push(8'h5C);
    n = 0;
    forever begin @(negedge clk); if (rd_en) break; n++; if (n > 200) break; end
    chk("timeout_latency", n, TO);
    wait_drained("timeout_drain");
    chk("timeout_data", tx_data, 8'h5C);
    chk("timeout_sent", sent, 5);

    // enable gating with a full FIFO
    @(posedge clk); #1;
    enable = 1'b0;
    for (int i = 0; i < 7; i++) push(8'h30 + 8'(i));
    bad = 0;
    repeat (30) begin @(negedge clk); if (rd_en || busy) bad++; end
    chk("gate_no_pop", bad, 0);
    chk("gate_occ", occ, 7);
    @(posedge clk); #1;
    enable = 1'b1;
    wait_drained("gate_drain");
    chk("gate_sent", sent, 12);
    chk("gate_occ_end", occ, 0);

    // transmitter stall at START
    @(posedge clk); #1;
    tx_force = 1'b1;
    push(8'hC0); push(8'hC1); push(8'hC2); push(8'hC3);
    wait_rd("stall_rd");
    @(negedge clk);
    @(negedge clk);
    d = tx_data;
    chk("stall_data", d, 8'hC0);
    repeat (8) begin
      @(negedge clk);
      chk("stall_start_low", tx_start, 0);
      chk("stall_data_hold", tx_data, d);
    end
    @(posedge clk); #1;
    tx_force = 1'b0;
    wait_drained("stall_drain");
    chk("stall_sent", sent, 16);

    // reset while a popped byte sits in CAPTURE
    push(8'hD0); push(8'hD1); push(8'hD2); push(8'hD3);
    wait_rd("rstmid_rd");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    wait_drained("rstmid_drain");
    chk("rstmid_sent", sent, 3);
    chk("rstmid_sb_empty", sbq.size(), 0);

    // enable drop during the second byte's WAIT_ACK
    do_reset(2);
    fixed_dur = 3;
    for (int i = 0; i < 5; i++) push(8'hE0 + 8'(i));
    n = 0;
    cnt = 0;
    while (cnt < 2 && n < 500) begin @(negedge clk); n++; if (tx_start) cnt++; end
    chk("drop_two_starts", cnt, 2);
    @(posedge clk); #1;
    enable = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (busy && n < 200);
    chk("drop_idle", busy, 0);
    chk("drop_occ", occ, 3);
    chk("drop_sent", sent, 2);
    @(posedge clk); #1;
    enable = 1'b1;
    wait_drained("drop_drain");
    chk("drop_sent_end", sent, 5);

    // randomized traffic
    fixed_dur = 0;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      enable = ($urandom_range(0, 7) != 0);
      room = wptr - rptr;
      if ($urandom_range(0, 2) == 0 && room != 3'd7) wr(8'($urandom));
    end
    @(posedge clk); #1;
    enable = 1'b1;
    wait_drained("rand_drain");
    chk("rand_sb_empty", sbq.size(), 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
